// File: rtl/imm_sequencer_pkg.sv
// Shared processor definitions for the immediate sequencer: opcode
// constants and the FSM state encoding.
package imm_sequencer_pkg;

   // Opcode values in instr[15:12]
   localparam logic [3:0] OPC_LDI = 4'h1;   // single-word signed 12-bit load
   localparam logic [3:0] OPC_LDH = 4'h2;   // prefix: imm[15:12] in instr[3:0]
   localparam logic [3:0] OPC_LDL = 4'h3;   // suffix: imm[11:0] unsigned

   // Sequencer FSM encoding
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PREFIX = 2'd1,
      HOLD   = 2'd2
   } state_t;

endpackage

// File: rtl/imm_sequencer_signextender.sv
// Sign extender: widens a 12-bit two's-complement field to 16 bits.
module signextender (
   input  logic [11:0] i_in,
   output logic [15:0] o_out
);

   // Replicate bit 11 into the upper nibble
   assign o_out = {{4{i_in[11]}}, i_in};

endmodule

// File: rtl/imm_sequencer.sv
// Immediate sequencer: assembles 16-bit immediates from LDI or LDH+LDL
// instruction sequences and presents them on a valid/ready output.
//
// Handshakes: an input word transfers on a rising edge where
// instr_valid && instr_ready; an immediate transfers on a rising edge
// where imm_valid && imm_ready. imm_valid never depends on imm_ready,
// and imm is held stable while imm_valid is high.
module imm_sequencer
   import imm_sequencer_pkg::*;
#(
   parameter logic [3:0] OP_LDI = OPC_LDI,
   parameter logic [3:0] OP_LDH = OPC_LDH,
   parameter logic [3:0] OP_LDL = OPC_LDL
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic [15:0] instr,
   output logic        instr_ready,
   output logic        imm_valid,
   output logic [15:0] imm,
   input  logic        imm_ready,
   output logic        err,
   output state_t      dbg_state
);

   state_t      r_state;
   logic [3:0]  r_hi;
   logic [15:0] r_imm;
   logic        r_err;

   logic        w_accept;
   logic [3:0]  w_opcode;
   logic [11:0] w_field;
   logic [15:0] w_sext;

   assign w_opcode = instr[15:12];
   assign w_field  = instr[11:0];

   // Input is only taken while no immediate is waiting for the consumer
   assign instr_ready = (r_state != HOLD);
   assign w_accept    = instr_valid && instr_ready;

   signextender u_sext (
      .i_in  (w_field),
      .o_out (w_sext)
   );

   // Sequencer FSM with hi-nibble, immediate and error-pulse registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_hi    <= 4'h0;
         r_imm   <= 16'h0000;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_opcode == OP_LDI) begin
                     r_imm   <= w_sext;
                     r_state <= HOLD;
                  end else if (w_opcode == OP_LDH) begin
                     r_hi    <= instr[3:0];
                     r_state <= PREFIX;
                  end else if (w_opcode == OP_LDL) begin
                     // Suffix without a prefix: drop it and flag
                     r_err <= 1'b1;
                  end
                  // Any other opcode is consumed silently
               end
            end
            PREFIX: begin
               if (w_accept) begin
                  if (w_opcode == OP_LDL) begin
                     r_imm   <= {r_hi, w_field};
                     r_state <= HOLD;
                  end else if (w_opcode == OP_LDI) begin
                     // Broken pair: discard prefix, still honour the LDI
                     r_err   <= 1'b1;
                     r_imm   <= w_sext;
                     r_state <= HOLD;
                  end else if (w_opcode == OP_LDH) begin
                     // Second prefix replaces the first
                     r_err <= 1'b1;
                     r_hi  <= instr[3:0];
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= IDLE;
                  end
               end
            end
            HOLD: begin
               if (imm_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign imm_valid = (r_state == HOLD);
   assign imm       = r_imm;
   assign err       = r_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_imm_sequencer.sv
// Testbench for imm_sequencer: directed instruction sequences with an
// expected-immediate queue and an expected-error queue checked by a monitor.
module tb_imm_sequencer;
   import imm_sequencer_pkg::*;

   logic        clk;
   logic        reset;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic        imm_valid;
   logic [15:0] imm;
   logic        imm_ready;
   logic        err;
   state_t      dbg_state;

   logic [15:0] exp_q[$];
   logic        exp_err_q[$];
   int          n_vec  = 0;
   int          n_fail = 0;
   logic        mon_en = 1'b0;

   imm_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .imm_valid   (imm_valid),
      .imm         (imm),
      .imm_ready   (imm_ready),
      .err         (err),
      .dbg_state   (dbg_state)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h, required %0h", name, act, exp);
      end
   endtask

   // Monitor: compares DUT outputs against the scoreboard queues
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && !reset) begin
            if (imm_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_imm_valid", {15'd0, imm_valid}, 32'd0);
               end else begin
                  chk("imm_value", {16'd0, imm}, {16'd0, exp_q[0]});
                  chk("instr_ready_in_hold", {31'd0, instr_ready}, 32'd0);
                  if (imm_ready) void'(exp_q.pop_front());
               end
            end
            if (err) begin
               if (exp_err_q.size() == 0) chk("unexpected_err", {31'd0, err}, 32'd0);
               else begin
                  void'(exp_err_q.pop_front());
                  n_vec++;
               end
            end
         end
      end
   end

   // Driver: present one word and hold it until it is accepted
   task automatic send(input logic [15:0] w);
      int budget = 0;
      instr       = w;
      instr_valid = 1'b1;
      while (!instr_ready && budget < 100) begin
         @(posedge clk); #1;
         budget++;
      end
      if (!instr_ready) begin
         chk("send_timeout", {31'd0, instr_ready}, 32'd1);
      end else begin
         @(posedge clk); #1;
      end
      instr_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int budget = 0;
      while (!(instr_ready && !imm_valid) && budget < 100) begin
         @(posedge clk); #1;
         budget++;
      end
      if (!(instr_ready && !imm_valid)) chk("idle_timeout", {31'd0, instr_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Stimulus
   initial begin
      reset       = 1'b1;
      instr_valid = 1'b0;
      instr       = 16'h0000;
      imm_ready   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      chk("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
      chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
      chk("rst_imm_valid", {31'd0, imm_valid}, 32'd0);
      chk("rst_imm", {16'd0, imm}, 32'h0000);
      chk("rst_err", {31'd0, err}, 32'd0);
      mon_en = 1'b1;

      // LDI sign extension, negative and positive edge values
      exp_q.push_back(16'hF800); send(16'h1800);
      exp_q.push_back(16'h07FF); send(16'h17FF);
      wait_idle();

      // LDH + LDL pair
      send(16'h200A);
      exp_q.push_back(16'hA123); send(16'h3123);
      wait_idle();

      // Back-pressure: immediate held for 5 cycles
      imm_ready = 1'b0;
      exp_q.push_back(16'hFFFF); send(16'h1FFF);
      idle_cycles(5);
      chk("hold_state", {30'd0, dbg_state}, {30'd0, HOLD});
      imm_ready = 1'b1;
      @(posedge clk); #1;
      chk("hold_release_valid", {31'd0, imm_valid}, 32'd0);
      chk("hold_release_ready", {31'd0, instr_ready}, 32'd1);
      wait_idle();

      // LDH then LDI: prefix dropped with error
      send(16'h2005);
      exp_err_q.push_back(1'b1); exp_q.push_back(16'h0001); send(16'h1001);
      wait_idle();

      // Orphan LDL and unknown opcode from IDLE
      exp_err_q.push_back(1'b1); send(16'h3ABC);
      wait_idle();
      send(16'h7123);
      wait_idle();
      chk("unknown_op_state", {30'd0, dbg_state}, {30'd0, IDLE});

      // Double prefix: second hi nibble wins
      send(16'h2003);
      exp_err_q.push_back(1'b1); send(16'h2004);
      exp_q.push_back(16'h4001); send(16'h3001);
      wait_idle();

      // Prefix followed by unknown opcode returns to IDLE with error
      send(16'h2009);
      exp_err_q.push_back(1'b1); send(16'h5000);
      wait_idle();
      chk("prefix_other_state", {30'd0, dbg_state}, {30'd0, IDLE});

      // Prefix held across a long idle gap
      send(16'h200B);
      idle_cycles(10);
      chk("prefix_hold_state", {30'd0, dbg_state}, {30'd0, PREFIX});
      exp_q.push_back(16'hBFFF); send(16'h3FFF);
      wait_idle();

      // Reset discards a pending prefix
      send(16'h2005);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("prefix_rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
      chk("prefix_rst_imm", {16'd0, imm}, 32'h0000);
      exp_err_q.push_back(1'b1); send(16'h3123);
      wait_idle();

      // Everything expected must have been observed
      chk("imm_queue_drained", exp_q.size(), 32'd0);
      chk("err_queue_drained", exp_err_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
